// File: rtl/hdmi_pkg.sv
// Shared TMDS definitions for the transmit encoder and receive decoder.
// Control tokens are written MSB..LSB; bit 0 goes out on the wire first.
package hdmi_pkg;
    localparam int TMDS_SYM_W = 10;
    localparam int PIX_W      = 8;

    localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    function automatic logic [TMDS_SYM_W-1:0] ctrl_token(input logic [1:0] ctrl);
        logic [TMDS_SYM_W-1:0] tok;
        case (ctrl)
            2'b00:   tok = CTRL_TOKEN_00;
            2'b01:   tok = CTRL_TOKEN_01;
            2'b10:   tok = CTRL_TOKEN_10;
            default: tok = CTRL_TOKEN_11;
        endcase
        return tok;
    endfunction
endpackage

// File: rtl/tmds_qm_stage.sv
// Transition-minimising XOR/XNOR chain plus popcount of the result.
// Latency: combinational; the parent registers the outputs.
// Backpressure: none, one pixel per cycle.
module tmds_qm_stage
    import hdmi_pkg::*;
(
    input  logic [PIX_W-1:0] i_data,
    output logic [PIX_W:0]   o_qm,
    output logic [3:0]       o_n1q
);
    logic [3:0]       n1d;
    logic             use_xnor;
    logic [PIX_W-1:0] chain;

    always_comb begin
        n1d = '0;
        for (int i = 0; i < PIX_W; i++) begin
            n1d = n1d + 4'(i_data[i]);
        end
        // XNOR is chosen for bright pixels so the chain produces fewer transitions.
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !i_data[0]);

        chain    = '0;
        chain[0] = i_data[0];
        for (int i = 1; i < PIX_W; i++) begin
            chain[i] = use_xnor ? ~(chain[i-1] ^ i_data[i]) : (chain[i-1] ^ i_data[i]);
        end
        o_qm = {~use_xnor, chain};

        o_n1q = '0;
        for (int i = 0; i < PIX_W; i++) begin
            o_n1q = o_n1q + 4'(chain[i]);
        end
    end
endmodule

// File: rtl/tmds_encoder.sv
// Single-channel TMDS 8b/10b encoder with running-disparity DC balance.
// Latency: 2 i_pixclk cycles input to o_tmds, one symbol per cycle.
// Backpressure: none; the serializer consumes a symbol every cycle.
module tmds_encoder
    import hdmi_pkg::*;
#(
    parameter int                    CNT_W     = 5,
    parameter logic [TMDS_SYM_W-1:0] RST_TOKEN = 10'b1101010100
) (
    input  logic                  i_pixclk,
    input  logic                  i_rst,
    input  logic                  i_de,
    input  logic [PIX_W-1:0]      i_data,
    input  logic [1:0]            i_ctrl,
    output logic [TMDS_SYM_W-1:0] o_tmds
);
    localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);
    localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);

    logic [PIX_W:0]          qm_d, qm_q;
    logic [3:0]              n1q_d, n1q_q;
    logic                    de_q;
    logic [1:0]              ctrl_q;
    logic [TMDS_SYM_W-1:0]   tmds_d, tmds_q;
    logic signed [CNT_W-1:0] cnt_d, cnt_q;

    logic signed [CNT_W-1:0] n1_s, n0_s, disp;
    logic                    qm8;

    tmds_qm_stage u_qm (
        .i_data (i_data),
        .o_qm   (qm_d),
        .o_n1q  (n1q_d)
    );

    always_ff @(posedge i_pixclk) begin
        if (i_rst) begin
            qm_q   <= '0;
            n1q_q  <= '0;
            de_q   <= 1'b0;
            ctrl_q <= '0;
            tmds_q <= RST_TOKEN;
            cnt_q  <= '0;
        end else begin
            qm_q   <= qm_d;
            n1q_q  <= n1q_d;
            de_q   <= i_de;
            ctrl_q <= i_ctrl;
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        n1_s   = CNT_W'(n1q_q);
        n0_s   = EIGHT - n1_s;
        disp   = n1_s - n0_s;
        qm8    = qm_q[PIX_W];
        tmds_d = ctrl_token(ctrl_q);
        cnt_d  = '0;

        if (de_q) begin
            if ((cnt_q == 0) || (n1_s == n0_s)) begin
                tmds_d = {~qm8, qm8, qm8 ? qm_q[PIX_W-1:0] : ~qm_q[PIX_W-1:0]};
                cnt_d  = qm8 ? (cnt_q + disp) : (cnt_q - disp);
            end else if (((cnt_q > 0) && (n1_s > n0_s)) || ((cnt_q < 0) && (n0_s > n1_s))) begin
                // Inverting pulls the line back toward zero disparity.
                tmds_d = {1'b1, qm8, ~qm_q[PIX_W-1:0]};
                cnt_d  = cnt_q + (qm8 ? TWO : '0) - disp;
            end else begin
                tmds_d = {1'b0, qm8, qm_q[PIX_W-1:0]};
                cnt_d  = cnt_q - (qm8 ? '0 : TWO) + disp;
            end
        end
    end

    assign o_tmds = tmds_q;
endmodule

// File: tb/tb_tmds_encoder.sv
// Directed and random checks of tmds_encoder against an arithmetic TMDS model,
// with loop-back decode and per-line disparity bound on the observed symbols.
module tb_tmds_encoder;
    logic       i_pixclk = 1'b0;
    logic       i_rst    = 1'b1;
    logic       i_de     = 1'b0;
    logic [7:0] i_data   = '0;
    logic [1:0] i_ctrl   = '0;
    logic [9:0] o_tmds;

    int errors = 0;
    int checks = 0;

    logic [9:0] tok [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    int         mcnt;
    int         ldisp;
    logic [9:0] pend_sym;
    logic       pend_de;
    logic [7:0] pend_data;
    logic [1:0] pend_ctrl;

    tmds_encoder dut (
        .i_pixclk (i_pixclk),
        .i_rst    (i_rst),
        .i_de     (i_de),
        .i_data   (i_data),
        .i_ctrl   (i_ctrl),
        .o_tmds   (o_tmds)
    );

    always #5 i_pixclk = ~i_pixclk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic de, input logic [7:0] data, input logic [1:0] ctrl,
                         output logic [9:0] sym);
        int         n1d, n1q, n0q;
        logic       use_xnor;
        logic [8:0] qm;
        if (!de) begin
            sym  = tok[ctrl];
            mcnt = 0;
            return;
        end
        n1d      = $countones(data);
        use_xnor = (n1d > 4) || (n1d == 4 && data[0] == 1'b0);
        qm[0]    = data[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ data[i]) : (qm[i-1] ^ data[i]);
        qm[8] = !use_xnor;
        n1q   = $countones(qm[7:0]);
        n0q   = 8 - n1q;
        if (mcnt == 0 || n1q == n0q) begin
            sym  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            mcnt = mcnt + (qm[8] ? (n1q - n0q) : (n0q - n1q));
        end else if ((mcnt > 0 && n1q > n0q) || (mcnt < 0 && n0q > n1q)) begin
            sym  = {1'b1, qm[8], ~qm[7:0]};
            mcnt = mcnt + 2 * int'(qm[8]) + (n0q - n1q);
        end else begin
            sym  = {1'b0, qm[8], qm[7:0]};
            mcnt = mcnt - 2 * int'(!qm[8]) + (n1q - n0q);
        end
    endtask

    // Receive-side decode: returns {is_ctrl, ctrl, data}.
    function automatic logic [10:0] decode(input logic [9:0] sym);
        logic [7:0] d, o;
        for (int t = 0; t < 4; t++) begin
            if (sym == tok[t]) return {1'b1, 2'(t), 8'h00};
        end
        d    = sym[9] ? ~sym[7:0] : sym[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) o[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return {1'b0, 2'b00, o};
    endfunction

    task automatic tick(input logic rst, input logic de, input logic [7:0] data,
                        input logic [1:0] ctrl);
        logic [9:0]  nsym;
        logic [10:0] dec_exp;
        @(negedge i_pixclk);
        i_rst  = rst;
        i_de   = de;
        i_data = data;
        i_ctrl = ctrl;
        @(posedge i_pixclk);
        #1;
        if (rst) begin
            chk("reset_token", o_tmds, 10'h354);
            mcnt      = 0;
            ldisp     = 0;
            pend_sym  = 10'h354;
            pend_de   = 1'b0;
            pend_data = '0;
            pend_ctrl = '0;
        end else begin
            chk("model", o_tmds, pend_sym);
            dec_exp = pend_de ? {1'b0, 2'b00, pend_data} : {1'b1, pend_ctrl, 8'h00};
            checks++;
            assert (decode(o_tmds) === dec_exp) else begin
                errors++;
                $error("FAIL loopback observed=%h expected=%h", decode(o_tmds), dec_exp);
            end
            if (pend_de) ldisp = ldisp + 2 * $countones(o_tmds) - 10;
            else         ldisp = 0;
            checks++;
            assert ((ldisp >= -10 && ldisp <= 10) === 1'b1) else begin
                errors++;
                $error("FAIL line_disparity observed=%0d expected=within +-10", ldisp);
            end
            model(de, data, ctrl, nsym);
            pend_sym  = nsym;
            pend_de   = de;
            pend_data = data;
            pend_ctrl = ctrl;
        end
    endtask

    initial begin
        mcnt      = 0;
        ldisp     = 0;
        pend_sym  = 10'h354;
        pend_de   = 1'b0;
        pend_data = '0;
        pend_ctrl = '0;

        // Reset held three cycles with active data on the inputs.
        repeat (3) tick(1'b1, 1'b1, 8'hA5, 2'b00);

        // All-zero pixels from cnt=0, then all-ones after a control symbol.
        tick(1'b0, 1'b1, 8'h00, 2'b00);
        tick(1'b0, 1'b1, 8'h00, 2'b00);
        chk("zero_1", o_tmds, 10'h100);
        tick(1'b0, 1'b1, 8'h00, 2'b00);
        chk("zero_2", o_tmds, 10'h3FF);
        tick(1'b0, 1'b0, 8'h00, 2'b00);
        chk("zero_3", o_tmds, 10'h100);
        tick(1'b0, 1'b1, 8'hFF, 2'b01);
        chk("ctrl_00", o_tmds, 10'h354);
        tick(1'b0, 1'b0, 8'h00, 2'b01);
        chk("ones_first", o_tmds, 10'h200);
        tick(1'b0, 1'b0, 8'h5A, 2'b10);
        chk("ctrl_01", o_tmds, 10'h0AB);
        tick(1'b0, 1'b0, 8'hC3, 2'b11);
        chk("ctrl_10", o_tmds, 10'h154);
        tick(1'b0, 1'b1, 8'h00, 2'b00);
        chk("ctrl_11", o_tmds, 10'h2AB);

        // Reset in the middle of a random burst, then refill.
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 8'($urandom), 2'($urandom));
        tick(1'b1, 1'b1, 8'($urandom), 2'b00);
        tick(1'b0, 1'b1, 8'h00, 2'b00);
        chk("post_rst_flush", o_tmds, 10'h354);
        tick(1'b0, 1'b1, 8'($urandom), 2'b00);
        chk("post_rst_first", o_tmds, 10'h100);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 8'($urandom), 2'($urandom));

        // Long random run with data-enable in bursts.
        for (int i = 0; i < 20000; i++) begin
            tick(1'b0, ($urandom_range(0, 15) != 0), 8'($urandom), 2'($urandom));
        end
        // Bias toward skewed pixels to stress the counter.
        for (int i = 0; i < 4000; i++) begin
            tick(1'b0, ($urandom_range(0, 31) != 0),
                 ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(252, 255)),
                 2'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
